// File: rtl/mips_pkg.sv
// Shared fetch-path definitions: default widths, reset vector, PC step and
// the state/select encodings used by the fetch unit and its PC register.
package mips_pkg;

   localparam int unsigned WIDTH_MEM = 32;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int unsigned PC_INC    = 32'd4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_DISCARD = 2'd2,
      ST_HOLD    = 2'd3
   } fetch_state_t;

   typedef enum logic [1:0] {
      PC_SEL_KEEP = 2'd0,
      PC_SEL_INC  = 2'd1,
      PC_SEL_LOAD = 2'd2
   } pc_sel_t;

endpackage

// File: rtl/pc_reg.sv
// Fetch PC register: holds the address being requested and selects between
// keep, step-from-delivered-PC and redirect load.
module pc_reg #(
   parameter int unsigned          WIDTH_MEM = mips_pkg::WIDTH_MEM,
   parameter logic [WIDTH_MEM-1:0] RESET_PC  = WIDTH_MEM'(mips_pkg::RESET_PC)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  mips_pkg::pc_sel_t    pc_sel,
   input  logic [WIDTH_MEM-1:0] inc_base,
   input  logic [WIDTH_MEM-1:0] load_addr,
   output logic [WIDTH_MEM-1:0] pc
);
   import mips_pkg::*;

   logic [WIDTH_MEM-1:0] pc_r;
   logic [WIDTH_MEM-1:0] pc_nxt_s;

   // Next-PC select; the increment wraps naturally at the top of the address space
   always_comb begin
      pc_nxt_s = pc_r;
      case (pc_sel)
         PC_SEL_KEEP: pc_nxt_s = pc_r;
         PC_SEL_INC:  pc_nxt_s = inc_base + WIDTH_MEM'(PC_INC);
         PC_SEL_LOAD: pc_nxt_s = load_addr & ~(WIDTH_MEM'(2'd3));
         default:     pc_nxt_s = pc_r;
      endcase
   end

   // PC state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pc_r <= RESET_PC;
      end else begin
         pc_r <= pc_nxt_s;
      end
   end

   assign pc = pc_r;

endmodule

// File: rtl/pc_fetch_unit.sv
// Single-outstanding instruction fetch unit: requests one word at a time,
// holds it until the consumer takes it, and handles redirects mid-flight.
module pc_fetch_unit #(
   parameter int unsigned          WIDTH_MEM = mips_pkg::WIDTH_MEM,
   parameter logic [WIDTH_MEM-1:0] RESET_PC  = WIDTH_MEM'(mips_pkg::RESET_PC)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_branch_taken,
   input  logic [WIDTH_MEM-1:0] i_branch_target,
   input  logic                 i_stall,
   output logic                 o_imem_req,
   output logic [WIDTH_MEM-1:0] o_imem_addr,
   input  logic                 i_imem_ack,
   input  logic [WIDTH_MEM-1:0] i_imem_rdata,
   output logic [WIDTH_MEM-1:0] o_instr,
   output logic                 o_instr_valid,
   output logic [WIDTH_MEM-1:0] o_pc,
   output logic [WIDTH_MEM-1:0] o_pc_plus4
);
   import mips_pkg::*;

   fetch_state_t         state_r, state_nxt_s;
   pc_sel_t              pc_sel_s;
   logic [WIDTH_MEM-1:0] fetch_pc_s;
   logic [WIDTH_MEM-1:0] load_addr_s;
   logic [WIDTH_MEM-1:0] tgt_aligned_s;
   logic [WIDTH_MEM-1:0] redir_r, redir_nxt_s;
   logic [WIDTH_MEM-1:0] instr_r, instr_nxt_s;
   logic [WIDTH_MEM-1:0] pc_r, pc_nxt_s;
   logic                 valid_r, valid_nxt_s;
   logic                 req_r, req_nxt_s;

   assign tgt_aligned_s = i_branch_target & ~(WIDTH_MEM'(2'd3));

   pc_reg #(
      .WIDTH_MEM (WIDTH_MEM),
      .RESET_PC  (RESET_PC)
   ) u_pc_reg (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .pc_sel    (pc_sel_s),
      .inc_base  (pc_r),
      .load_addr (load_addr_s),
      .pc        (fetch_pc_s)
   );

   // Next-state, PC select and output-register updates
   always_comb begin
      state_nxt_s = state_r;
      pc_sel_s    = PC_SEL_KEEP;
      load_addr_s = tgt_aligned_s;
      redir_nxt_s = redir_r;
      instr_nxt_s = instr_r;
      pc_nxt_s    = pc_r;
      valid_nxt_s = valid_r;
      case (state_r)
         ST_IDLE: begin
            state_nxt_s = ST_REQ;
         end
         ST_REQ: begin
            if (i_imem_ack) begin
               if (i_branch_taken) begin
                  pc_sel_s    = PC_SEL_LOAD;
                  state_nxt_s = ST_REQ;
               end else begin
                  instr_nxt_s = i_imem_rdata;
                  pc_nxt_s    = fetch_pc_s;
                  valid_nxt_s = 1'b1;
                  state_nxt_s = ST_HOLD;
               end
            end else if (i_branch_taken) begin
               // the request in flight must complete at its original address
               redir_nxt_s = tgt_aligned_s;
               state_nxt_s = ST_DISCARD;
            end else begin
               state_nxt_s = ST_REQ;
            end
         end
         ST_DISCARD: begin
            if (i_imem_ack) begin
               pc_sel_s    = PC_SEL_LOAD;
               load_addr_s = i_branch_taken ? tgt_aligned_s : redir_r;
               state_nxt_s = ST_REQ;
            end else if (i_branch_taken) begin
               redir_nxt_s = tgt_aligned_s;
               state_nxt_s = ST_DISCARD;
            end else begin
               state_nxt_s = ST_DISCARD;
            end
         end
         ST_HOLD: begin
            if (i_branch_taken) begin
               valid_nxt_s = 1'b0;
               pc_sel_s    = PC_SEL_LOAD;
               state_nxt_s = ST_REQ;
            end else if (valid_r && !i_stall) begin
               valid_nxt_s = 1'b0;
               pc_sel_s    = PC_SEL_INC;
               state_nxt_s = ST_REQ;
            end else begin
               state_nxt_s = ST_HOLD;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Request line is registered from the next state so it is glitch-free
   always_comb begin
      req_nxt_s = (state_nxt_s == ST_REQ) || (state_nxt_s == ST_DISCARD);
   end

   // FSM and output registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r <= ST_IDLE;
         redir_r <= '0;
         instr_r <= '0;
         pc_r    <= RESET_PC;
         valid_r <= 1'b0;
         req_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         redir_r <= redir_nxt_s;
         instr_r <= instr_nxt_s;
         pc_r    <= pc_nxt_s;
         valid_r <= valid_nxt_s;
         req_r   <= req_nxt_s;
      end
   end

   assign o_imem_req    = req_r;
   assign o_imem_addr   = fetch_pc_s;
   assign o_instr       = instr_r;
   assign o_instr_valid = valid_r;
   assign o_pc          = pc_r;
   assign o_pc_plus4    = pc_r + WIDTH_MEM'(PC_INC);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by
// random traffic, compared each cycle against a transaction-level model.
module tb_pc_fetch_unit;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_branch_taken;
   logic [31:0] i_branch_target;
   logic        i_stall;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ack;
   logic [31:0] i_imem_rdata;
   logic [31:0] o_instr;
   logic        o_instr_valid;
   logic [31:0] o_pc;
   logic [31:0] o_pc_plus4;

   int n_cmp  = 0;
   int n_fail = 0;

   // model: what the consumer and the memory should observe
   logic        m_boot;
   logic        m_req;
   logic [31:0] m_fetch;
   logic        m_doomed;
   logic [31:0] m_redir;
   logic        m_valid;
   logic [31:0] m_pc;
   logic [31:0] m_instr;

   pc_fetch_unit dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_branch_taken  (i_branch_taken),
      .i_branch_target (i_branch_target),
      .i_stall         (i_stall),
      .o_imem_req      (o_imem_req),
      .o_imem_addr     (o_imem_addr),
      .i_imem_ack      (i_imem_ack),
      .i_imem_rdata    (i_imem_rdata),
      .o_instr         (o_instr),
      .o_instr_valid   (o_instr_valid),
      .o_pc            (o_pc),
      .o_pc_plus4      (o_pc_plus4)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("req", {31'd0, o_imem_req}, {31'd0, m_req});
      if (m_req) chk("addr", o_imem_addr, m_fetch);
      chk("valid", {31'd0, o_instr_valid}, {31'd0, m_valid});
      chk("pc", o_pc, m_pc);
      chk("instr", o_instr, m_instr);
      chk("pc_plus4", o_pc_plus4, m_pc + 32'd4);
   endtask

   task automatic model_reset();
      m_boot   = 1'b1;
      m_req    = 1'b0;
      m_fetch  = 32'h0;
      m_doomed = 1'b0;
      m_redir  = 32'h0;
      m_valid  = 1'b0;
      m_pc     = 32'h0;
      m_instr  = 32'h0;
   endtask

   // one clock of stimulus, model update on the edge, full check mid-cycle
   task automatic cycle(input logic br, input logic [31:0] tgt, input logic stall,
                        input logic ack, input logic [31:0] rdata);
      i_branch_taken  = br;
      i_branch_target = tgt;
      i_stall         = stall;
      i_imem_ack      = ack;
      i_imem_rdata    = rdata;
      @(posedge i_clk);
      if (m_boot) begin
         m_boot = 1'b0;
         m_req  = 1'b1;
      end else if (m_req) begin
         if (ack && (m_doomed || br)) begin
            m_fetch  = br ? (tgt & ~32'd3) : m_redir;
            m_doomed = 1'b0;
         end else if (ack) begin
            m_valid = 1'b1;
            m_pc    = m_fetch;
            m_instr = rdata;
            m_req   = 1'b0;
         end else if (br) begin
            m_doomed = 1'b1;
            m_redir  = tgt & ~32'd3;
         end
      end else if (m_valid && (br || !stall)) begin
         m_fetch = br ? (tgt & ~32'd3) : m_pc + 32'd4;
         m_valid = 1'b0;
         m_req   = 1'b1;
      end
      @(negedge i_clk);
      check_all();
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_branch_taken = 1'b0; i_branch_target = 32'h0; i_stall = 1'b0;
      i_imem_ack = 1'b0; i_imem_rdata = 32'h0;
      model_reset();
      @(negedge i_clk);
      @(negedge i_clk);
      check_all();
      i_rst = 1'b0;
   endtask

   initial begin
      int n4;
      do_reset();

      // back-to-back fetch from reset: 0x0, 0x4, 0x8
      for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1, $urandom);
      chk("seq_pc8", o_pc, 32'h8);
      chk("seq_valid", {31'd0, o_instr_valid}, 32'd1);

      // stall while holding 0x8
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 32'h0, 1'b1, 1'b1, $urandom);
         chk("stall_noreq", {31'd0, o_imem_req}, 32'd0);
         chk("stall_pc", o_pc, 32'h8);
      end
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("stall_release_addr", o_imem_addr, 32'hC);
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_2222);
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("req_0x10", o_imem_addr, 32'h10);

      // redirect while the 0x10 request is pending
      cycle(1'b1, 32'h103, 1'b0, 1'b0, 32'h0);
      chk("discard_addr_kept", o_imem_addr, 32'h10);
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
      chk("discard_no_valid", {31'd0, o_instr_valid}, 32'd0);
      chk("redirect_addr", o_imem_addr, 32'h100);
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFE_0100);
      chk("redirect_pc", o_pc, 32'h100);
      chk("redirect_instr", o_instr, 32'hCAFE_0100);

      // wrap from the top of the address space
      cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0);
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h7777_7777);
      chk("top_pc", o_pc, 32'hFFFF_FFFC);
      chk("top_plus4", o_pc_plus4, 32'h0);
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("wrap_addr", o_imem_addr, 32'h0);

      // asynchronous reset in the middle of a request, ack during reset
      #2;
      i_rst = 1'b1;
      i_imem_ack = 1'b1;
      #1;
      chk("async_req", {31'd0, o_imem_req}, 32'd0);
      chk("async_valid", {31'd0, o_instr_valid}, 32'd0);
      model_reset();
      @(negedge i_clk);
      check_all();
      i_rst = 1'b0;
      i_imem_ack = 1'b0;
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("post_reset_req", {31'd0, o_imem_req}, 32'd1);
      chk("post_reset_addr", o_imem_addr, 32'h0);

      // ack delayed 3 cycles at 0x4
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'hA0A0_0000);
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      n4 = (o_imem_req && o_imem_addr == 32'h4) ? 1 : 0;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
         if (o_imem_req && o_imem_addr == 32'h4) n4++;
      end
      chk("delay_req_cycles", n4, 32'd4);
      cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'hA0A0_0004);
      chk("delay_valid", {31'd0, o_instr_valid}, 32'd1);
      chk("delay_pc", o_pc, 32'h4);

      // random traffic against the model
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 2) == 0),
               $urandom_range(0, 1) == 1, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
